// File: rtl/network_div_pkg.sv
// Shared widths, saturation limits, FSM encoding and magnitude helper for the sequential signed divider.
package network_div_pkg;

  localparam int unsigned DIVIDEND_W = 30;
  localparam int unsigned DIVISOR_W  = 15;
  localparam int unsigned QUOTIENT_W = 16;
  localparam int unsigned CNT_W      = 5;

  localparam logic signed [QUOTIENT_W-1:0] QMAX = QUOTIENT_W'((1 << (QUOTIENT_W - 1)) - 1);
  localparam logic signed [QUOTIENT_W-1:0] QMIN = QUOTIENT_W'(1 << (QUOTIENT_W - 1));

  // Largest quotient magnitudes that survive saturation, per result sign
  localparam logic [DIVIDEND_W-1:0] QMAG_POS = DIVIDEND_W'((1 << (QUOTIENT_W - 1)) - 1);
  localparam logic [DIVIDEND_W-1:0] QMAG_NEG = DIVIDEND_W'(1 << (QUOTIENT_W - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement magnitude; the most negative value maps onto its unsigned magnitude
  function automatic logic [DIVIDEND_W-1:0] mag(input logic [DIVIDEND_W-1:0] x);
    mag = x[DIVIDEND_W-1] ? (DIVIDEND_W'(0) - x) : x;
  endfunction

endpackage

// File: rtl/network_div_seq_core.sv
// Unsigned radix-2 restoring iterator: one quotient bit per step, partial remainder kept at divisor width.
module network_div_seq_core
  import network_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic                  step,
  input  logic [DIVIDEND_W-1:0] dvd_mag,
  input  logic [DIVISOR_W-1:0]  dvs_mag,
  output logic [DIVIDEND_W-1:0] quo_mag,
  output logic [DIVISOR_W-1:0]  rem_mag,
  output logic                  last_c
);

  logic [DIVISOR_W-1:0]  prem;
  logic [DIVIDEND_W-1:0] dq;
  logic [DIVISOR_W-1:0]  dvs_r;
  logic [CNT_W-1:0]      cnt;

  logic [DIVISOR_W-1:0]  trial;
  logic [DIVISOR_W-1:0]  diff;
  logic                  ge;

  // Partial remainder stays below the divisor magnitude, so its top bit is free for the shift
  always_comb begin
    trial  = {prem[DIVISOR_W-2:0], dq[DIVIDEND_W-1]};
    ge     = (trial >= dvs_r);
    diff   = trial - dvs_r;
    last_c = step && (cnt == CNT_W'(DIVIDEND_W - 1));
  end

  assign quo_mag = dq;
  assign rem_mag = prem;

  // Dividend bits shift out of the top of dq while quotient bits shift in at the bottom
  always_ff @(posedge clk) begin
    if (!reset) begin
      prem  <= '0;
      dq    <= '0;
      dvs_r <= '0;
      cnt   <= '0;
    end else if (ce) begin
      if (start) begin
        prem  <= '0;
        dq    <= dvd_mag;
        dvs_r <= dvs_mag;
        cnt   <= '0;
      end else if (step) begin
        prem <= ge ? diff : trial;
        dq   <= {dq[DIVIDEND_W-2:0], ge};
        cnt  <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/network_div_seq_30s_15s_16.sv
// Sequential signed divider 30s / 15s -> 16s quotient + 15s remainder with sign fix-up and saturation.
module network_div_seq_30s_15s_16
  import network_div_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic signed [DIVISOR_W-1:0]  divisor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [QUOTIENT_W-1:0] quotient,
  output logic signed [DIVISOR_W-1:0]  remainder,
  output logic                         ovf,
  output logic                         dbz
);

  state_t state;

  logic sign_dvd;
  logic sign_dvs;
  logic zero_dvs;

  logic                  start;
  logic                  step;
  logic                  last_c;
  logic [DIVIDEND_W-1:0] dvd_mag;
  logic [DIVIDEND_W-1:0] dvs_wide;
  logic [DIVIDEND_W-1:0] dvs_wide_mag;
  logic [DIVISOR_W-1:0]  dvs_mag;
  logic [DIVIDEND_W-1:0] quo_mag;
  logic [DIVISOR_W-1:0]  rem_mag;

  logic signed [QUOTIENT_W-1:0] q_fix;
  logic signed [DIVISOR_W-1:0]  r_fix;
  logic                         ovf_fix;
  logic                         dbz_fix;
  logic                         q_neg;

  // Divisor is sign-extended so a single magnitude helper covers both operands
  always_comb begin
    dvd_mag      = mag(dividend);
    dvs_wide     = {{(DIVIDEND_W - DIVISOR_W){divisor[DIVISOR_W-1]}}, divisor};
    dvs_wide_mag = mag(dvs_wide);
    dvs_mag      = dvs_wide_mag[DIVISOR_W-1:0];
    start        = (state == IDLE) && in_valid;
    step         = (state == CALC);
  end

  network_div_seq_core u_core (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .start   (start),
    .step    (step),
    .dvd_mag (dvd_mag),
    .dvs_mag (dvs_mag),
    .quo_mag (quo_mag),
    .rem_mag (rem_mag),
    .last_c  (last_c)
  );

  // Sign fix-up and clamp of the unsigned core result
  always_comb begin
    q_neg   = sign_dvd ^ sign_dvs;
    q_fix   = QUOTIENT_W'(quo_mag);
    r_fix   = sign_dvd ? (DIVISOR_W'(0) - rem_mag) : rem_mag;
    ovf_fix = 1'b0;
    dbz_fix = 1'b0;
    if (zero_dvs) begin
      q_fix   = sign_dvd ? QMIN : QMAX;
      r_fix   = '0;
      ovf_fix = 1'b1;
      dbz_fix = 1'b1;
    end else if (!q_neg) begin
      if (quo_mag > QMAG_POS) begin
        q_fix   = QMAX;
        ovf_fix = 1'b1;
      end
    end else begin
      if (quo_mag > QMAG_NEG) begin
        q_fix   = QMIN;
        ovf_fix = 1'b1;
      end else begin
        q_fix = QUOTIENT_W'(0) - quo_mag[QUOTIENT_W-1:0];
      end
    end
  end

  // Control FSM; handshake flags are registered alongside the state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
      sign_dvd  <= 1'b0;
      sign_dvs  <= 1'b0;
      zero_dvs  <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_dvd <= dividend[DIVIDEND_W-1];
            sign_dvs <= divisor[DIVISOR_W-1];
            zero_dvs <= (divisor == '0);
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (last_c) state <= FIX;
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          ovf       <= ovf_fix;
          dbz       <= dbz_fix;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_network_div_seq_30s_15s_16.sv
// Scoreboard bench for the sequential signed divider: directed vectors, latency, back-pressure, ce stall, reset abort.
module tb_network_div_seq_30s_15s_16;

  logic               clk;
  logic               reset;
  logic               ce;
  logic               in_valid;
  logic               in_ready;
  logic signed [29:0] dividend;
  logic signed [14:0] divisor;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] quotient;
  logic signed [14:0] remainder;
  logic               ovf;
  logic               dbz;

  typedef struct {
    int q;
    int r;
    int ovf;
    int dbz;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  network_div_seq_30s_15s_16 dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // Monitor: pops the scoreboard on every accepted result
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (reset && ce && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("quotient", int'(quotient), e.q);
        check("remainder", int'(remainder), e.r);
        check("ovf", int'(ovf), e.ovf);
        check("dbz", int'(dbz), e.dbz);
      end
    end
  end

  task automatic do_op(input int dvd, input int dvs, input int eq, input int er,
                       input int eovf, input int edbz, input int exp_lat,
                       input int stall_at, input int hold);
    exp_t e;
    int   lat;
    int   n;
    bit   seen;
    bit   stable;
    logic signed [15:0] q0;
    logic signed [14:0] r0;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_op", int'(in_ready), 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    dividend  = 30'(dvd);
    divisor   = 15'(dvs);
    e.q = eq; e.r = er; e.ovf = eovf; e.dbz = edbz;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      ce = !(stall_at > 0 && lat >= stall_at && lat < stall_at + 5);
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = out_valid;
    end
    ce = 1'b1;
    check("latency", lat, exp_lat);
    if (hold > 0) begin
      q0 = quotient;
      r0 = remainder;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (quotient != q0 || remainder != r0 || !out_valid || in_ready) stable = 1'b0;
      end
      check("hold_stable", int'(stable), 1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    check("in_ready_after_done", int'(in_ready), 1);
  endtask

  initial begin
    reset     = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_flags", int'({ovf, dbz}), 0);
    reset = 1'b1;

    do_op(1000, 7, 142, 6, 0, 0, 31, 0, 0);
    do_op(-1000, 7, -142, -6, 0, 0, 31, 0, 0);
    do_op(1000, -7, -142, 6, 0, 0, 31, 0, 0);
    do_op(-1000, -7, 142, -6, 0, 0, 31, 0, 0);
    do_op(536870911, 1, 32767, 0, 1, 0, 31, 0, 0);
    do_op(-32768, 1, -32768, 0, 0, 0, 31, 0, 0);
    do_op(-536870912, -16384, 32767, 0, 1, 0, 31, 0, 0);
    do_op(12345, 0, 32767, 0, 1, 1, 31, 0, 0);
    do_op(-5, 0, -32768, 0, 1, 1, 31, 0, 0);
    do_op(30000, -123, -243, 111, 0, 0, 31, 0, 10);
    do_op(70000, 255, 274, 130, 0, 0, 36, 8, 0);

    // Abort an operation mid-iteration with reset
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 30'(1000);
    divisor  = 15'(7);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_quotient", int'(quotient), 0);
    reset = 1'b1;
    do_op(100, 3, 33, 1, 0, 0, 31, 0, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
